// File: rtl/branch_target_predictor.sv
// Fetch-stage branch target buffer with 2-bit direction counters.
// Predictions ride a PIPE_DEPTH pipe to the resolve stage, where they are checked and trained.
module branch_target_predictor #(
  parameter int unsigned BIT_COUNT  = 32,
  parameter int unsigned ENTRIES    = 16,
  parameter int unsigned TAG_BITS   = 8,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BIT_COUNT-1:0] PC_I,
  input  logic [BIT_COUNT-1:0] PCp4_I,
  input  logic                 FetchValid_I,
  input  logic                 Stall,
  input  logic                 Flush,
  output logic                 Predict,
  output logic [BIT_COUNT-1:0] Prediction,
  output logic [BIT_COUNT-1:0] PCNextPred,
  input  logic                 Resolve_C,
  input  logic [BIT_COUNT-1:0] ResolvePC_C,
  input  logic                 ResolveTaken_C,
  input  logic [BIT_COUNT-1:0] ResolveTarget_C,
  output logic                 PredictionCorrect_C,
  output logic                 Mispredict_C,
  output logic [BIT_COUNT-1:0] RecoverPC_C
);

  localparam int unsigned IDX = $clog2(ENTRIES);
  // Targets are stored without bit 0, which is always zero on output.
  localparam int unsigned TW  = BIT_COUNT - 1;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TW-1:0]       target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [PIPE_DEPTH-1:0] pv_q;
  logic [PIPE_DEPTH-1:0] ptaken_q;
  logic [TW-1:0]         ptarget_q [PIPE_DEPTH];

  logic [IDX-1:0]       f_idx, r_idx;
  logic [TAG_BITS-1:0]  f_tag, r_tag;
  logic                 f_hit, r_hit;
  logic                 tail_taken;
  logic                 match;
  logic [BIT_COUNT-1:0] recover_sum;
  logic                 unused_bits;

  assign f_idx = PC_I[IDX+1:2];
  assign f_tag = PC_I[IDX+TAG_BITS+1:IDX+2];
  assign r_idx = ResolvePC_C[IDX+1:2];
  assign r_tag = ResolvePC_C[IDX+TAG_BITS+1:IDX+2];

  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

  assign Predict    = FetchValid_I & f_hit & ctr_q[f_idx][1];
  assign Prediction = {target_q[f_idx], 1'b0};
  assign PCNextPred = Predict ? Prediction : {PCp4_I[BIT_COUNT-1:1], 1'b0};

  // An invalid tail entry behaves as a not-taken prediction.
  assign tail_taken = pv_q[PIPE_DEPTH-1] & ptaken_q[PIPE_DEPTH-1];
  assign match      = (ResolveTaken_C == tail_taken) &&
                      (!ResolveTaken_C ||
                       (ResolveTarget_C[BIT_COUNT-1:1] == ptarget_q[PIPE_DEPTH-1]));

  assign PredictionCorrect_C = Resolve_C & match;
  assign Mispredict_C        = Resolve_C & ~match;

  assign recover_sum = ResolvePC_C + BIT_COUNT'(4);
  assign RecoverPC_C = ResolveTaken_C ? {ResolveTarget_C[BIT_COUNT-1:1], 1'b0}
                                      : {recover_sum[BIT_COUNT-1:1], 1'b0};

  assign unused_bits = ^{PC_I, PCp4_I[0], ResolveTarget_C[0], recover_sum[0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pv_q     <= '0;
      ptaken_q <= '0;
      for (int i = 0; i < int'(PIPE_DEPTH); i++) ptarget_q[i] <= '0;
    end else begin
      if (!Stall) begin
        for (int i = int'(PIPE_DEPTH) - 1; i > 0; i--) begin
          pv_q[i]      <= pv_q[i-1];
          ptaken_q[i]  <= ptaken_q[i-1];
          ptarget_q[i] <= ptarget_q[i-1];
        end
        pv_q[0]      <= FetchValid_I;
        ptaken_q[0]  <= Predict;
        ptarget_q[0] <= target_q[f_idx];
      end
      // Flush wins over stall and over the shift above.
      if (Flush || Mispredict_C) pv_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (Resolve_C && !Stall) begin
      if (r_hit) begin
        if (ResolveTaken_C) begin
          if (ctr_q[r_idx] != 2'b11) ctr_q[r_idx] <= ctr_q[r_idx] + 2'b01;
          target_q[r_idx] <= ResolveTarget_C[BIT_COUNT-1:1];
        end else if (ctr_q[r_idx] != 2'b00) begin
          ctr_q[r_idx] <= ctr_q[r_idx] - 2'b01;
        end
      end else if (ResolveTaken_C) begin
        valid_q[r_idx]  <= 1'b1;
        tag_q[r_idx]    <= r_tag;
        target_q[r_idx] <= ResolveTarget_C[BIT_COUNT-1:1];
        ctr_q[r_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed plus random stimulus for branch_target_predictor, checked against a
// table/queue reference model of the predictor behaviour.
module tb_branch_target_predictor;

  localparam int ENTRIES    = 16;
  localparam int TAG_BITS   = 8;
  localparam int PIPE_DEPTH = 2;
  localparam int IDX        = $clog2(ENTRIES);

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] PC_I, PCp4_I, Prediction, PCNextPred;
  logic        FetchValid_I, Stall, Flush, Predict;
  logic        Resolve_C, ResolveTaken_C, PredictionCorrect_C, Mispredict_C;
  logic [31:0] ResolvePC_C, ResolveTarget_C, RecoverPC_C;

  int n_asserts;
  int n_fail;

  branch_target_predictor #(
    .BIT_COUNT(32), .ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS), .PIPE_DEPTH(PIPE_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .PC_I(PC_I), .PCp4_I(PCp4_I),
    .FetchValid_I(FetchValid_I), .Stall(Stall), .Flush(Flush), .Predict(Predict),
    .Prediction(Prediction), .PCNextPred(PCNextPred), .Resolve_C(Resolve_C),
    .ResolvePC_C(ResolvePC_C), .ResolveTaken_C(ResolveTaken_C),
    .ResolveTarget_C(ResolveTarget_C), .PredictionCorrect_C(PredictionCorrect_C),
    .Mispredict_C(Mispredict_C), .RecoverPC_C(RecoverPC_C)
  );

  always #5 clk = ~clk;

  // Reference model: table as arrays of plain values, prediction pipe as a queue.
  typedef struct { bit v; bit taken; logic [31:0] tgt; } pent_t;
  bit          m_valid  [ENTRIES];
  int          m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  pent_t       pq[$];   // pq[0] is the resolve-stage entry

  bit          e_hit, e_predict, e_correct, e_mis;
  logic [31:0] e_prediction, e_pcnext, e_recover;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> (2 + IDX)) % (1 << TAG_BITS));
  endfunction

  task automatic model_reset();
    pent_t e;
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
    end
    pq.delete();
    e.v = 0; e.taken = 0; e.tgt = 0;
    for (int i = 0; i < PIPE_DEPTH; i++) pq.push_back(e);
  endtask

  task automatic compute_expect();
    int    fi;
    bit    tk;
    fi           = idx_of(PC_I);
    e_hit        = m_valid[fi] && (m_tag[fi] == tag_of(PC_I));
    e_predict    = FetchValid_I && e_hit && (m_ctr[fi] >= 2);
    e_prediction = m_target[fi];
    e_pcnext     = e_predict ? e_prediction : (PCp4_I & ~32'h1);
    tk           = pq[0].v && pq[0].taken;
    e_correct    = Resolve_C && (ResolveTaken_C == tk) &&
                   (!ResolveTaken_C || ((ResolveTarget_C & ~32'h1) == pq[0].tgt));
    e_mis        = Resolve_C && !e_correct;
    e_recover    = ResolveTaken_C ? (ResolveTarget_C & ~32'h1) : ((ResolvePC_C + 32'd4) & ~32'h1);
  endtask

  task automatic model_edge();
    pent_t e;
    int    ri;
    compute_expect();
    if (!Stall) begin
      e.v = FetchValid_I; e.taken = e_predict; e.tgt = e_prediction;
      void'(pq.pop_front());
      pq.push_back(e);
    end
    if (Flush || e_mis) foreach (pq[i]) pq[i].v = 0;
    if (Resolve_C && !Stall) begin
      ri = idx_of(ResolvePC_C);
      if (m_valid[ri] && m_tag[ri] == tag_of(ResolvePC_C)) begin
        if (ResolveTaken_C) begin
          m_ctr[ri]    = (m_ctr[ri] == 3) ? 3 : m_ctr[ri] + 1;
          m_target[ri] = ResolveTarget_C & ~32'h1;
        end else begin
          m_ctr[ri] = (m_ctr[ri] == 0) ? 0 : m_ctr[ri] - 1;
        end
      end else if (ResolveTaken_C) begin
        m_valid[ri] = 1; m_tag[ri] = tag_of(ResolvePC_C);
        m_target[ri] = ResolveTarget_C & ~32'h1; m_ctr[ri] = 2;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    compute_expect();
    check("predict", {31'b0, Predict}, {31'b0, e_predict});
    check("pcnextpred", PCNextPred, e_pcnext);
    if (e_hit) check("prediction", Prediction, e_prediction);
    check("correct", {31'b0, PredictionCorrect_C}, {31'b0, e_correct});
    check("mispredict", {31'b0, Mispredict_C}, {31'b0, e_mis});
    if (Resolve_C) check("recoverpc", RecoverPC_C, e_recover);
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic fv, input logic st, input logic fl,
                       input logic rs, input logic [31:0] rpc, input logic rtk,
                       input logic [31:0] rtg);
    PC_I = pc; PCp4_I = pc + 32'd4; FetchValid_I = fv; Stall = st; Flush = fl;
    Resolve_C = rs; ResolvePC_C = rpc; ResolveTaken_C = rtk; ResolveTarget_C = rtg;
  endtask

  task automatic fetch(input logic [31:0] pc);
    drive(pc, 1, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic idle();
    drive(32'h40, 0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic resolve(input logic [31:0] rpc, input logic rtk, input logic [31:0] rtg);
    drive(32'h40, 0, 0, 0, 1, rpc, rtk, rtg);
  endtask

  // Fetch only, with an explicit expectation on the direction.
  task automatic probe(input string tag, input logic [31:0] pc, input logic exp_pred);
    fetch(pc);
    #1;
    check(tag, {31'b0, Predict}, {31'b0, exp_pred});
    cycle();
  endtask

  function automatic logic [31:0] pick_pc();
    logic [31:0] r;
    case ($urandom_range(0, 8))
      0: return 32'h100;
      1: return 32'h500;
      2: return 32'h1FC;
      3: return 32'h104;
      4: return 32'h900;
      5: return 32'h3C0;
      6: return 32'hFFFF_FFFC;
      default: begin r = $urandom; return r & ~32'h3; end
    endcase
  endfunction

  function automatic logic [31:0] pick_tgt();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0: return 32'h200;
      1: return 32'h300;
      2: return 32'h600;
      default: begin r = $urandom; return r; end
    endcase
  endfunction

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    reset_n   = 1'b1;
    fetch(32'h100);
    model_reset();
    #1 reset_n = 1'b0;
    #2;
    check("rst_predict", {31'b0, Predict}, 32'h0);
    check("rst_pcnext", PCNextPred, 32'h104);
    check("rst_mispredict", {31'b0, Mispredict_C}, 32'h0);
    check("rst_correct", {31'b0, PredictionCorrect_C}, 32'h0);
    #9 reset_n = 1'b1;
    @(posedge clk); #1;

    // First fetch misses; resolving taken allocates and redirects.
    fetch(32'h100); #1;
    check("tp1_pcnext", PCNextPred, 32'h104);
    cycle();
    idle(); cycle();
    resolve(32'h100, 1, 32'h200); #1;
    check("tp1_mispredict", {31'b0, Mispredict_C}, 32'h1);
    check("tp1_recover", RecoverPC_C, 32'h200);
    cycle();
    fetch(32'h100); #1;
    check("tp1_prediction", Prediction, 32'h200);
    check("tp1_predict", {31'b0, Predict}, 32'h1);
    cycle();
    idle(); cycle(); idle(); cycle();

    // Counter saturation at both ends.
    repeat (3) begin resolve(32'h100, 1, 32'h200); cycle(); end
    resolve(32'h100, 0, 32'h0); cycle();
    probe("sat_hi_still_taken", 32'h100, 1);
    resolve(32'h100, 0, 32'h0); cycle();
    probe("sat_weak_nt", 32'h100, 0);
    repeat (3) begin resolve(32'h100, 0, 32'h0); cycle(); end
    resolve(32'h100, 1, 32'h200); cycle();
    probe("sat_lo_one_up", 32'h100, 0);
    resolve(32'h100, 1, 32'h200); cycle();
    probe("sat_lo_two_up", 32'h100, 1);
    idle(); cycle();

    // Target change on a predicted-taken branch.
    fetch(32'h100); cycle();
    idle(); cycle();
    resolve(32'h100, 1, 32'h300); #1;
    check("tgt_mispredict", {31'b0, Mispredict_C}, 32'h1);
    check("tgt_recover", RecoverPC_C, 32'h300);
    cycle();
    fetch(32'h100); #1;
    check("tgt_prediction", Prediction, 32'h300);
    cycle();
    idle(); cycle(); idle(); cycle();

    // Predicted taken, actually not taken: redirect to fall-through and clear the pipe.
    resolve(32'h1FC, 1, 32'h400); cycle();
    fetch(32'h1FC); cycle();
    fetch(32'h1FC); cycle();
    resolve(32'h1FC, 0, 32'h0); #1;
    check("nt_mispredict", {31'b0, Mispredict_C}, 32'h1);
    check("nt_recover", RecoverPC_C, 32'h200);
    cycle();
    resolve(32'h1FC, 0, 32'h0); #1;
    check("nt_after_flush_correct", {31'b0, PredictionCorrect_C}, 32'h1);
    cycle();

    // Aliasing: 0x500 shares the index of 0x100 with a different tag.
    resolve(32'h500, 1, 32'h600); cycle();
    probe("alias_old_miss", 32'h100, 0);
    fetch(32'h500); #1;
    check("alias_new_prediction", Prediction, 32'h600);
    check("alias_new_predict", {31'b0, Predict}, 32'h1);
    cycle();

    // Stall: tail holds, table does not train.
    idle(); cycle();
    repeat (3) begin
      drive(32'h900, 1, 1, 0, 1, 32'h500, 1, 32'h600); #1;
      check("stall_correct", {31'b0, PredictionCorrect_C}, 32'h1);
      cycle();
    end
    resolve(32'h500, 0, 32'h0); cycle();
    probe("stall_no_train", 32'h500, 0);

    // Flush under stall still clears the pipe.
    resolve(32'h500, 1, 32'h600); cycle();
    fetch(32'h500); cycle();
    drive(32'h900, 1, 1, 1, 0, 32'h0, 0, 32'h0); cycle();
    idle(); cycle();
    resolve(32'h500, 1, 32'h600); #1;
    check("flush_stall_mispredict", {31'b0, Mispredict_C}, 32'h1);
    cycle();

    // Asynchronous reset mid-stream.
    fetch(32'h500); #1;
    check("pre_rst_predict", {31'b0, Predict}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_predict", {31'b0, Predict}, 32'h0);
    model_reset();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    probe("post_rst_miss", 32'h500, 0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      drive(pick_pc(), $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, pick_pc(),
            $urandom_range(0, 1) == 1, pick_tgt());
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Fetch-stage branch target buffer with 2-bit saturating direction counters. It supplies a predicted next PC for the instruction being fetched and carries each prediction down a pipeline to the C (resolve) stage. In C it compares the prediction against the actual outcome, drives PredictionCorrect_C and the mispredict redirect to the PC update logic, and trains the table.

## Interface
Parameters:
- BIT_COUNT, 32, datapath/PC width
- ENTRIES, 16, table entries; power of 2, at least 2; IDX = log2(ENTRIES)
- TAG_BITS, 8, tag width; BIT_COUNT ≥ IDX+TAG_BITS+2
- PIPE_DEPTH, 2, stages from fetch (I) to resolve (C); at least 1

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- PC_I  in  BIT_COUNT  PC of the instruction being fetched
- PCp4_I  in  BIT_COUNT  PC_I+4
- FetchValid_I  in  1  the fetch slot holds a real instruction
- Stall  in  1  freeze the prediction pipe and suppress training
- Flush  in  1  external flush; invalidates all in-flight predictions
- Predict  out  1  fetch predicted taken
- Prediction  out  BIT_COUNT  predicted target, bit 0 forced to 0
- PCNextPred  out  BIT_COUNT  Predict ? Prediction : {PCp4_I[BIT_COUNT-1:1],0}
- Resolve_C  in  1  a branch or jump resolves in C this cycle
- ResolvePC_C  in  BIT_COUNT  PC of the resolving instruction
- ResolveTaken_C  in  1  actual direction
- ResolveTarget_C  in  BIT_COUNT  actual target
- PredictionCorrect_C  out  1  Resolve_C and prediction matched
- Mispredict_C  out  1  Resolve_C and prediction wrong
- RecoverPC_C  out  BIT_COUNT  correct next PC on mispredict, bit 0 forced to 0

## Operation
- Entry fields: valid, tag[TAG_BITS], target[BIT_COUNT], ctr[2].
- Index and tag: idx = PC[IDX+1:2]; tag = PC[IDX+TAG_BITS+1:IDX+2].
- Lookup is combinational from registered state: hit = valid[idx] & tag match; Predict = FetchValid_I & hit & ctr[1]; Prediction = {target[BIT_COUNT-1:1],0}.
- Prediction pipe: PIPE_DEPTH registers of {v, taken, target}.
  - Each non-stalled cycle, the head loads {FetchValid_I, Predict, Prediction} and the rest shift.
  - The tail is the C-stage entry.
- Compare against the tail (tail.v=0 counts as predicted not-taken). match = (ResolveTaken_C == tail.taken) & (!ResolveTaken_C | ResolveTarget_C[BIT_COUNT-1:1] == tail.target[BIT_COUNT-1:1]).
  - PredictionCorrect_C = Resolve_C & match.
  - Mispredict_C = Resolve_C & !match.
- RecoverPC_C = ResolveTaken_C ? {ResolveTarget_C[BIT_COUNT-1:1],0} : ResolvePC_C+4, with wrap-around modulo 2^BIT_COUNT and bit 0 cleared.
- Training, on an edge with Resolve_C & !Stall, using idx/tag of ResolvePC_C:
  - Hit: ctr increments when taken and decrements when not, saturating at 3 and 0. If taken, target is rewritten.
  - Miss and taken: allocate the entry (valid=1, new tag, target, ctr=2'b10), overwriting any previous occupant.
  - Miss and not taken: no change.
- Flush priority: Flush or Mispredict_C clears every pipe v bit at the edge. This takes priority over Stall. Training on a mispredicting resolve still occurs when !Stall.

## Timing
- Reset (async assert, sync to clk on deassert): all valid=0, all ctr=2'b01, all pipe v=0.
  - Outputs during and after reset: Predict=0, PCNextPred={PCp4_I[..:1],0}, PredictionCorrect_C=0, Mispredict_C=0.
  - Reset mid-operation discards all state immediately.
- Lookup latency is 0 cycles; a trained entry is visible to lookup on the cycle after the training edge.
- Same-cycle lookup and training on the same idx: lookup returns the pre-update value.
- A prediction fetched at cycle t reaches the tail at cycle t+PIPE_DEPTH, less any stalled cycles.
- Mispredict_C, RecoverPC_C and PredictionCorrect_C are combinational in the cycle Resolve_C is high.
- Stall held: pipe contents, table, and C-stage outputs stay stable given stable inputs.

## Test plan
- Reset, then PC_I=0x100 with FetchValid_I=1 -> Predict=0 and PCNextPred=0x104. Resolve 0x100 taken to 0x200 -> Mispredict_C=1 and RecoverPC_C=0x200. Next fetch of 0x100 -> Predict=1 and Prediction=0x200.
- Saturation: from ctr=10, resolve 0x100 taken 3× then not-taken 1× -> still predicts taken. Then not-taken 1× more -> Predict=0 (ctr=01). Not-taken 3× more -> ctr stays at 00.
- Target change: entry 0x100→0x200, resolve taken to 0x300 with predicted 0x200 -> Mispredict_C=1 and RecoverPC_C=0x300. Next lookup gives Prediction=0x300.
- Predicted taken, actual not taken at ResolvePC_C=0x1FC -> Mispredict_C=1, RecoverPC_C=0x200, and all pipe entries invalidated. A resolve on the following cycle with no new fetches compares as not-taken.
- Aliasing (ENTRIES=16): train 0x100, then resolve 0x500 taken (same idx, different tag) -> 0x100 no longer hits and 0x500 hits with ctr=10.
- Stall for 3 cycles with Resolve_C=1 -> no table change and the tail is unchanged. Flush with Stall=1 -> pipe cleared. reset_n pulsed mid-stream -> Predict=0 immediately.
